// File: rtl/frame_write_arbiter_if.sv
// rtl/frame_write_arbiter_if.sv - request and frame buffer write bus for frame_write_arbiter
interface frame_write_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              start_clear;
  logic              blue_req;
  logic [ADDR_W-1:0] blue_addr;
  logic [15:0]       blue_data;
  logic              blue_ack;
  logic              red_req;
  logic [ADDR_W-1:0] red_addr;
  logic [15:0]       red_data;
  logic              red_ack;
  logic              WE;
  logic [ADDR_W-1:0] write_address;
  logic [15:0]       Data_In;
  logic              clear_busy;
  logic              clear_done;

  // Requester / trail-logic side
  modport master (
    output start_clear, blue_req, blue_addr, blue_data, red_req, red_addr, red_data,
    input  blue_ack, red_ack, WE, write_address, Data_In, clear_busy, clear_done
  );

  // Arbiter side
  modport slave (
    input  start_clear, blue_req, blue_addr, blue_data, red_req, red_addr, red_data,
    output blue_ack, red_ack, WE, write_address, Data_In, clear_busy, clear_done
  );
endinterface

// File: rtl/frame_write_arbiter.sv
// rtl/frame_write_arbiter.sv - frame buffer write port arbiter with built-in clear sweep
module frame_write_arbiter #(
  parameter int          WORDS      = 153600,
  parameter int          ADDR_W     = 19,
  parameter logic [15:0] CLEAR_WORD = 16'h0808
) (
  input  logic                 Clk,
  input  logic                 Reset,
  frame_write_arbiter_if.slave bus
);
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // One extra bit so the counter can sit at WORDS for the done cycle without aliasing address 0
  localparam int              CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WORDS);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_red_q, last_red_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              back_q, back_d;
  logic              rack_q, rack_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // A requester whose ack is high this cycle still holds its old request, so it is not eligible
  logic blue_elig, red_elig;
  assign blue_elig = bus.blue_req & ~back_q;
  assign red_elig  = bus.red_req  & ~rack_q;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start_clear only honoured in IDLE; sweep ends once every word has been written
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_clear) state_d = S_CLEAR;
      S_CLEAR: if (cnt_q == CNT_END) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: clear write, round-robin grant, or idle hold
  always_comb begin
    cnt_d      = cnt_q;
    last_red_d = last_red_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    back_d     = 1'b0;
    rack_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_clear) begin
          cnt_d = '0;
        end else if (blue_elig && (!red_elig || last_red_q)) begin
          we_d       = 1'b1;
          addr_d     = bus.blue_addr;
          data_d     = bus.blue_data;
          back_d     = 1'b1;
          last_red_d = 1'b0;
        end else if (red_elig) begin
          we_d       = 1'b1;
          addr_d     = bus.red_addr;
          data_d     = bus.red_data;
          rack_d     = 1'b1;
          last_red_d = 1'b1;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CNT_END) begin
          done_d = 1'b1;
        end else begin
          we_d   = 1'b1;
          addr_d = cnt_q[ADDR_W-1:0];
          data_d = CLEAR_WORD;
          busy_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and arbitration history
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q      <= '0;
      last_red_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      back_q     <= 1'b0;
      rack_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      last_red_q <= last_red_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      back_q     <= back_d;
      rack_q     <= rack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.WE            = we_q;
  assign bus.write_address = addr_q;
  assign bus.Data_In       = data_q;
  assign bus.blue_ack      = back_q;
  assign bus.red_ack       = rack_q;
  assign bus.clear_busy    = busy_q;
  assign bus.clear_done    = done_q;
endmodule

// File: tb/tb_frame_write_arbiter.sv
// tb/tb_frame_write_arbiter.sv - randomized self-checking bench for frame_write_arbiter
module tb_frame_write_arbiter;
  localparam int          WORDS      = 40;
  localparam int          ADDR_W     = 19;
  localparam logic [15:0] CLEAR_WORD = 16'h0808;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  frame_write_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  frame_write_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W), .CLEAR_WORD(CLEAR_WORD)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: sweep position (-1 = not sweeping, WORDS = done pending) and last winner
  int                clr_idx;
  bit                m_last_red;
  bit                m_we, m_back, m_rack, m_busy, m_done;
  logic [ADDR_W-1:0] m_addr;
  logic [15:0]       m_data;

  int seen [WORDS];
  bit track_sweep = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] obs_vec();
    return {24'd0, bus.WE, bus.blue_ack, bus.red_ack, bus.clear_busy, bus.clear_done,
            bus.write_address, bus.Data_In};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {24'd0, m_we, m_back, m_rack, m_busy, m_done, m_addr, m_data};
  endfunction

  task automatic model_reset();
    clr_idx = -1; m_last_red = 1'b1;
    m_we = 0; m_back = 0; m_rack = 0; m_busy = 0; m_done = 0;
    m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit eb, er;
    eb = bus.blue_req && !m_back;
    er = bus.red_req && !m_rack;
    m_we = 0; m_back = 0; m_rack = 0; m_busy = 0; m_done = 0;
    if (clr_idx == WORDS) begin
      m_done = 1; clr_idx = -1;
    end else if (clr_idx >= 0) begin
      m_we = 1; m_busy = 1; m_addr = ADDR_W'(clr_idx); m_data = CLEAR_WORD; clr_idx++;
    end else if (bus.start_clear) begin
      clr_idx = 0;
    end else if (eb && (!er || m_last_red)) begin
      m_we = 1; m_back = 1; m_addr = bus.blue_addr; m_data = bus.blue_data; m_last_red = 0;
    end else if (er) begin
      m_we = 1; m_rack = 1; m_addr = bus.red_addr; m_data = bus.red_data; m_last_red = 1;
    end
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_step();
    #1;
    if (track_sweep && bus.WE && bus.clear_busy && int'(bus.write_address) < WORDS)
      seen[int'(bus.write_address)]++;
    check(tag, obs_vec(), exp_vec());
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.start_clear = 0; bus.blue_req = 0; bus.red_req = 0;
    #1;
    model_reset();
    check("reset_async", obs_vec(), 64'd0);
    @(posedge Clk);
    #1;
    check("reset_hold", obs_vec(), exp_vec());
    Reset = 1'b0;
  endtask

  task automatic new_blue();
    bus.blue_req = 1; bus.blue_addr = ADDR_W'($urandom); bus.blue_data = 16'($urandom);
  endtask

  task automatic new_red();
    bus.red_req = 1; bus.red_addr = ADDR_W'($urandom); bus.red_data = 16'($urandom);
  endtask

  initial begin
    int once;
    bus.start_clear = 0;
    bus.blue_req = 0; bus.blue_addr = '0; bus.blue_data = '0;
    bus.red_req  = 0; bus.red_addr  = '0; bus.red_data  = '0;
    model_reset();
    do_reset();

    // Lone blue request, held past its ack
    bus.blue_req = 1; bus.blue_addr = 19'd100; bus.blue_data = 16'h0404;
    step("lone_grant");
    check("lone_blue", {bus.WE, bus.blue_ack, bus.write_address, bus.Data_In},
          {1'b1, 1'b1, 19'd100, 16'h0404});
    step("lone_gap");
    check("no_dup", bus.WE, 0);
    bus.blue_req = 0;
    step("lone_drop");

    // Two continuous requesters alternate, blue first after reset
    do_reset();
    bus.blue_req = 1; bus.blue_addr = 19'd5; bus.blue_data = 16'h0101;
    bus.red_req  = 1; bus.red_addr  = 19'd9; bus.red_data  = 16'h0202;
    for (int i = 0; i < 6; i++) begin
      step("alt");
      check("alt_seq", {bus.WE, bus.blue_ack, bus.red_ack, bus.write_address},
            {1'b1, (i % 2 == 0), (i % 2 == 1), ((i % 2 == 0) ? 19'd5 : 19'd9)});
    end
    bus.blue_req = 0; bus.red_req = 0;
    step("alt_drop");

    // Full sweep with a red request arriving mid-sweep and an ignored start_clear
    for (int i = 0; i < WORDS; i++) seen[i] = 0;
    track_sweep = 1;
    bus.start_clear = 1;
    step("clr_start");
    check("clr_bubble", bus.WE, 0);
    bus.start_clear = 0;
    for (int i = 0; i < WORDS; i++) begin
      step("clr_sweep");
      check("clr_word", {bus.WE, bus.clear_busy, bus.red_ack, bus.write_address, bus.Data_In},
            {1'b1, 1'b1, 1'b0, ADDR_W'(i), CLEAR_WORD});
      bus.start_clear = (i == 15);
      if (i == 10) begin
        bus.red_req = 1; bus.red_addr = 19'd7; bus.red_data = 16'h0c0c;
      end
    end
    bus.start_clear = 0;
    step("clr_done");
    check("clr_done_pulse", {bus.WE, bus.clear_busy, bus.clear_done, bus.red_ack}, 4'b0010);
    step("red_after");
    check("red_after_clear", {bus.WE, bus.red_ack, bus.write_address}, {1'b1, 1'b1, 19'd7});
    bus.red_req = 0;
    track_sweep = 0;
    once = 0;
    for (int i = 0; i < WORDS; i++) if (seen[i] == 1) once++;
    check("sweep_once", once, WORDS);
    step("idle");
    check("done_one_cycle", bus.clear_done, 0);

    // start_clear together with a fresh blue request: clear wins, blue waits
    bus.start_clear = 1;
    bus.blue_req = 1; bus.blue_addr = 19'd33; bus.blue_data = 16'h0e0e;
    step("sc_blue");
    check("sc_no_blue", {bus.WE, bus.blue_ack}, 2'b00);
    bus.start_clear = 0;
    for (int i = 0; i < WORDS + 1; i++) step("sc_wait");
    check("sc_done", bus.clear_done, 1);
    step("sc_grant");
    check("sc_blue_after", {bus.WE, bus.blue_ack, bus.write_address}, {1'b1, 1'b1, 19'd33});
    bus.blue_req = 0;
    step("sc_idle");

    // Reset mid-sweep, then restart from address 0
    bus.start_clear = 1;
    step("rs_start");
    bus.start_clear = 0;
    for (int i = 0; i < 21; i++) step("rs_sweep");
    check("rs_at_20", bus.write_address, 20);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("rs_quiet");
      check("rs_no_done", {bus.WE, bus.clear_busy, bus.clear_done}, 3'b000);
    end
    bus.start_clear = 1;
    step("rs_restart");
    bus.start_clear = 0;
    step("rs_first");
    check("rs_addr0", {bus.WE, bus.clear_busy, bus.write_address}, {1'b1, 1'b1, 19'd0});
    for (int i = 0; i < WORDS + 1; i++) step("rs_finish");

    // Randomized requesters, occasional clears and resets
    for (int c = 0; c < 2000; c++) begin
      bus.start_clear = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      step("rand");
      if (bus.blue_req && m_back) begin
        if ($urandom_range(0, 1) == 1) new_blue(); else bus.blue_req = 0;
      end else if (!bus.blue_req && $urandom_range(0, 2) == 0) new_blue();
      if (bus.red_req && m_rack) begin
        if ($urandom_range(0, 1) == 1) new_red(); else bus.red_req = 0;
      end else if (!bus.red_req && $urandom_range(0, 2) == 0) new_red();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
